// File: rtl/light_ctrl_pkg.sv
// Shared state encoding, timer width and light-override helper for the
// occupancy-based room light controller.
package light_ctrl_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2
    } light_state_t;

    // Wall switches win over the sensor-driven FSM; "off" beats "on".
    function automatic logic apply_override(input logic force_off,
                                            input logic force_on,
                                            input logic fsm_light);
        return force_off ? 1'b0 : (force_on ? 1'b1 : fsm_light);
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Single-bit rising-edge detector; the event is combinational from the
// live input against its registered history.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic ev
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign ev = sig & ~sig_q;

endmodule

// File: rtl/occupancy_light_ctrl.sv
// Room light controller: counts people through the door sensors, keeps the
// light on while occupied, holds it for OFF_DELAY cycles after emptying.
module occupancy_light_ctrl
    import light_ctrl_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int OFF_DELAY = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entering,
    input  logic             leaving,
    input  logic             override_on,
    input  logic             override_off,
    output logic             light,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0]   OCC_MAX   = {CNT_W{1'b1}};
    localparam logic [TIMER_W-1:0] HOLD_INIT = TIMER_W'(OFF_DELAY - 1);

    logic               ent_ev;
    logic               lv_ev;
    logic [CNT_W-1:0]   occ_nxt;
    logic               underflow_hit;
    logic [TIMER_W-1:0] timer;
    light_state_t       state;

    rise_edge u_ent_edge (.clk(clk), .rst_n(rst_n), .sig(entering), .ev(ent_ev));
    rise_edge u_lv_edge  (.clk(clk), .rst_n(rst_n), .sig(leaving),  .ev(lv_ev));

    // Simultaneous entry and exit cancel; both ends saturate instead of wrapping.
    always_comb begin
        occ_nxt       = occupancy;
        underflow_hit = 1'b0;
        if (ent_ev && !lv_ev) begin
            if (occupancy != OCC_MAX) begin
                occ_nxt = occupancy + 1'b1;
            end
        end else if (lv_ev && !ent_ev) begin
            if (occupancy == '0) begin
                underflow_hit = 1'b1;
            end else begin
                occ_nxt = occupancy - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy     <= '0;
            full          <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            occupancy <= occ_nxt;
            full      <= (occ_nxt == OCC_MAX);
            if (underflow_hit) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // The FSM runs off occ_nxt so the light tracks the same edge that changes the count;
    // overrides only gate the light register, never the state or timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            timer <= '0;
            light <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (occ_nxt != '0) begin
                        state <= ON;
                        light <= apply_override(override_off, override_on, 1'b1);
                    end else begin
                        light <= apply_override(override_off, override_on, 1'b0);
                    end
                end
                ON: begin
                    if (occ_nxt == '0) begin
                        state <= HOLD;
                        timer <= HOLD_INIT;
                    end
                    light <= apply_override(override_off, override_on, 1'b1);
                end
                HOLD: begin
                    if (occ_nxt != '0) begin
                        state <= ON;
                        light <= apply_override(override_off, override_on, 1'b1);
                    end else if (timer == '0) begin
                        state <= OFF;
                        light <= apply_override(override_off, override_on, 1'b0);
                    end else begin
                        timer <= timer - 1'b1;
                        light <= apply_override(override_off, override_on, 1'b1);
                    end
                end
                default: begin
                    state <= OFF;
                    light <= apply_override(override_off, override_on, 1'b0);
                end
            endcase
        end
    end

endmodule
